fsm1_pulse_monitor: RTL and testbench
=====================================

FSM1_PULSE_MONITOR -- requirements
Module: fsm1_pulse_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning capture FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the output1 window counter.
REQ-003 SHALL have port GCLK_Pad  input  1  sampling clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_Pad  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port tick_Pad  input  1  single-cycle strobe marking the end of one FSM clock window and the start of the next.
REQ-006 SHALL have port state_obs0_Pad  input  1  single-cycle pulse from FSM state observation bit 0.
REQ-007 SHALL have port state_obs1_Pad  input  1  single-cycle pulse from FSM state observation bit 1.
REQ-008 SHALL have port output1_Pad  input  1  single-cycle pulse from FSM output1.
REQ-009 SHALL have port rd_ready  input  1  reader accepts rd_data this cycle.
REQ-010 SHALL have port rd_valid  output  1  FIFO head word available.
REQ-011 SHALL have port rd_data  output  4  head word: [3] multi-pulse error, [2] output1 seen, [1] obs1 seen, [0] obs0 seen.
REQ-012 SHALL have port overflow  output  1  sticky flag: a window word was dropped.
REQ-013 SHALL have port out1_count  output  CNT_W  number of closed windows with output1 seen, saturating.
REQ-014 SHALL have port fill_level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL implement two states: UNARMED (after reset) and OPEN.
REQ-016 SHALL, in UNARMED, ignore all observation pulses; first tick_Pad moves to OPEN and pushes nothing.
REQ-017 SHALL, in OPEN, set a per-line sticky bit on any pulse; a second pulse on the same line in one window sets the sticky error bit.
REQ-018 SHALL assign a pulse coincident with tick_Pad to the window being closed.
REQ-019 SHALL, on tick_Pad in OPEN, form the word from sticky bits OR same-cycle pulses, push it, clear all sticky bits, and stay in OPEN.
REQ-020 SHALL make a pushed word visible on rd_data/rd_valid the cycle after the tick (no same-cycle bypass).
REQ-021 SHALL pop the head word when rd_valid and rd_ready are both high; rd_ready while empty has no effect.
REQ-022 SHALL, on tick with FIFO full and no pop that cycle, drop the word and set overflow; overflow clears only on reset.
REQ-023 SHALL, on tick with FIFO full and a pop the same cycle, accept the push; occupancy unchanged.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; fill_level ranges 0..DEPTH.
REQ-025 SHALL increment out1_count on every closed window with output1 seen, including dropped words; it holds at 2^CNT_W-1.
REQ-026 SHALL drive rd_data to 0 when rd_valid is low.

Reset
REQ-027 SHALL, while reset_Pad is high, force UNARMED, empty FIFO, all sticky bits 0, rd_valid 0, rd_data 0, overflow 0, out1_count 0, fill_level 0.
REQ-028 SHALL discard a partially collected window on reset mid-window; no word is pushed.
REQ-029 SHALL require a fresh tick_Pad after reset release before any capture.

Verification
REQ-030 SHALL cover: reset, obs0 pulse, tick, obs0 pulse, tick -> exactly one word 4'b0001 one cycle after second tick; first pulse ignored.
REQ-031 SHALL cover: armed, output1 and obs1 pulses, tick coincident with obs0 pulse -> word 4'b0111, out1_count=1.
REQ-032 SHALL cover: armed, two obs1 pulses in one window, tick -> word 4'b1010.
REQ-033 SHALL cover: rd_ready=0, DEPTH+1 ticks with output1 each window -> fill_level=DEPTH, overflow=1, out1_count=DEPTH+1, first DEPTH words read back in order.
REQ-034 SHALL cover: FIFO full, tick with rd_ready=1 same cycle -> overflow stays 0, fill_level stays DEPTH.
REQ-035 SHALL cover: reset asserted mid-window after obs0 pulse, released, tick, tick -> single word 4'b0000, rd_valid low until then.

Source files
------------

// File: rtl/fsm1_pulse_monitor_if.sv
// rtl/fsm1_pulse_monitor_if.sv - observation pulses in, captured window words out
//   tick_Pad                       : window boundary strobe (master -> slave)
//   state_obs0/1_Pad, output1_Pad  : single-cycle observation pulses (master -> slave)
//   rd_ready                       : reader accepts rd_data (master -> slave)
//   rd_valid, rd_data[3:0]         : FIFO head word (slave -> master)
//   overflow, out1_count, fill_level : status (slave -> master)
interface fsm1_pulse_monitor_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int FW = $clog2(DEPTH) + 1;

  logic             tick_Pad;
  logic             state_obs0_Pad;
  logic             state_obs1_Pad;
  logic             output1_Pad;
  logic             rd_ready;
  logic             rd_valid;
  logic [3:0]       rd_data;
  logic             overflow;
  logic [CNT_W-1:0] out1_count;
  logic [FW-1:0]    fill_level;

  modport master (
    output tick_Pad, state_obs0_Pad, state_obs1_Pad, output1_Pad, rd_ready,
    input  rd_valid, rd_data, overflow, out1_count, fill_level
  );

  modport slave (
    input  tick_Pad, state_obs0_Pad, state_obs1_Pad, output1_Pad, rd_ready,
    output rd_valid, rd_data, overflow, out1_count, fill_level
  );
endinterface

// File: rtl/fsm1_pulse_monitor.sv
// rtl/fsm1_pulse_monitor.sv - per-window FSM pulse capture into a small FIFO
//   GCLK_Pad  : sampling clock, rising edge
//   reset_Pad : asynchronous active-high reset
//   bus       : fsm1_pulse_monitor_if.slave (pulses and tick in, FIFO head and status out)
module fsm1_pulse_monitor #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 GCLK_Pad,
  input  logic                 reset_Pad,
  fsm1_pulse_monitor_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {UNARMED = 1'b0, OPEN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sticky_q, sticky_d;
  logic             err_q, err_d;
  logic [3:0]       mem_q [DEPTH];
  logic [3:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] out1_cnt_q, out1_cnt_d;

  logic [2:0] pulses;
  logic [3:0] word;
  logic       full;
  logic       pop;
  logic       push_acc;

  assign pulses = {bus.output1_Pad, bus.state_obs1_Pad, bus.state_obs0_Pad};
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign pop    = (count_q != '0) && bus.rd_ready;

  // Window contents including this cycle's pulses; a pulse on a line that is
  // already sticky is a repeat within the window and raises the error bit.
  assign word = {err_q | (|(sticky_q & pulses)), sticky_q | pulses};

  always_comb begin
    state_d    = state_q;
    sticky_d   = sticky_q;
    err_d      = err_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    out1_cnt_d = out1_cnt_q;
    push_acc   = 1'b0;

    if (state_q == UNARMED) begin
      // Pulses before the first tick belong to no complete window.
      if (bus.tick_Pad) state_d = OPEN;
    end else if (bus.tick_Pad) begin
      sticky_d = '0;
      err_d    = 1'b0;
      // A same-cycle pop frees a slot, so a full FIFO can still accept.
      if (!full || pop) begin
        push_acc        = 1'b1;
        mem_d[wr_ptr_q] = word;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        overflow_d = 1'b1;
      end
      // Counted on every closed window, dropped or not.
      if (word[2] && (out1_cnt_q != '1)) out1_cnt_d = out1_cnt_q + CNT_W'(1);
    end else begin
      sticky_d = word[2:0];
      err_d    = word[3];
    end

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_acc, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge GCLK_Pad or posedge reset_Pad) begin
    if (reset_Pad) begin
      state_q    <= UNARMED;
      sticky_q   <= '0;
      err_q      <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      out1_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sticky_q   <= sticky_d;
      err_q      <= err_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      out1_cnt_q <= out1_cnt_d;
    end
  end

  assign bus.rd_valid   = (count_q != '0);
  assign bus.rd_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 4'b0000;
  assign bus.overflow   = overflow_q;
  assign bus.out1_count = out1_cnt_q;
  assign bus.fill_level = count_q;
endmodule

// File: tb/tb_fsm1_pulse_monitor.sv
// tb/tb_fsm1_pulse_monitor.sv - scoreboard bench for fsm1_pulse_monitor
module tb_fsm1_pulse_monitor;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fsm1_pulse_monitor_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus();

  fsm1_pulse_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .GCLK_Pad  (clk),
    .reset_Pad (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: window pulse counts, expected word queue, occupancy.
  logic [3:0] exp_q[$];
  bit armed;
  int cnt0, cnt1, cnt2;
  int mfill, mcnt;
  bit movf;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    armed = 0; cnt0 = 0; cnt1 = 0; cnt2 = 0;
    mfill = 0; mcnt = 0; movf = 0;
  endfunction

  function automatic void model_cycle(bit t, bit a, bit b, bit c, bit r);
    bit pop, acc;
    logic [3:0] w;
    pop = (mfill > 0) && r;
    acc = 0;
    if (!armed) begin
      if (t) armed = 1;
    end else begin
      cnt0 += a; cnt1 += b; cnt2 += c;
      if (t) begin
        w = {(cnt0 > 1) || (cnt1 > 1) || (cnt2 > 1), cnt2 > 0, cnt1 > 0, cnt0 > 0};
        if (mfill < DEPTH || pop) begin
          acc = 1;
          exp_q.push_back(w);
        end else begin
          movf = 1;
        end
        if (w[2] && mcnt < CMAX) mcnt++;
        cnt0 = 0; cnt1 = 0; cnt2 = 0;
      end
    end
    mfill = mfill + int'(acc) - int'(pop);
  endfunction

  task automatic check_status();
    chk("fill_level", int'(bus.fill_level), mfill);
    chk("rd_valid",   int'(bus.rd_valid), int'(mfill > 0));
    chk("overflow",   int'(bus.overflow), int'(movf));
    chk("out1_count", int'(bus.out1_count), mcnt);
  endtask

  task automatic drive(bit t, bit a, bit b, bit c, bit r);
    bus.tick_Pad       = t;
    bus.state_obs0_Pad = a;
    bus.state_obs1_Pad = b;
    bus.output1_Pad    = c;
    bus.rd_ready       = r;
  endtask

  task automatic step(bit t, bit a, bit b, bit c, bit r);
    @(posedge clk); #1;
    check_status();
    drive(t, a, b, c, r);
    model_cycle(t, a, b, c, r);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      check_status();
      chk("rd_data_in_reset", int'(bus.rd_data), 0);
    end
    rst = 1'b0;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(0, 0, 0, 0, 1);
  endtask

  // Monitor: compares the head word whenever the DUT presents one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rd_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", int'(bus.rd_data), -1);
          end else begin
            chk("rd_data", int'(bus.rd_data), int'(exp_q[0]));
            if (bus.rd_ready) void'(exp_q.pop_front());
          end
        end else begin
          chk("rd_data_idle", int'(bus.rd_data), 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 0, 0);
    model_reset();
    do_reset();

    // Ignored pre-arm pulse, then one captured obs0 window.
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    drain();

    // output1 + obs1, tick coincident with obs0.
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    drain();

    // Repeated obs1 in one window.
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    drain();

    // Overflow: DEPTH+1 windows with no reader.
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    drain();

    // Full FIFO with a pop on the tick cycle.
    do_reset();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, i[0], 1, 0, 0);
      step(1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    drain();

    // Reset mid-window discards the partial window and disarms.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1);
      end
    end
    drain();
    step(0, 0, 0, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
